// File: rtl/cont_delay_net.sv
// -----------------------------------------------------------------------------
// cont_delay_net
//
// Cycle-based model of a multi-driver 4-state wire net. Each driver passes
// through its own inertial delay stage with programmable rise/fall/turn-off
// delays. The effective driver values are then combined with wire resolution
// into a registered net value.
//
// 4-state encoding (2 bits per net bit): 00=0, 01=1, 10=z, 11=x.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   drv_val   in   [N_DRV*W*2]  requested driver values, driver i at [i*2W +: 2W]
//   dly_rise  in   [N_DRV*DW]   per-driver rise delay (cycles)
//   dly_fall  in   [N_DRV*DW]   per-driver fall delay (cycles)
//   dly_off   in   [N_DRV*DW]   per-driver turn-off delay (cycles)
//   drv_eff   out  [N_DRV*W*2]  effective (delayed) driver values
//   drv_busy  out  [N_DRV]      driver i has a pending transition
//   net       out  [W*2]        resolved net value (lags drv_eff by one cycle)
//   net_chg   out               one-cycle pulse after net changes
// -----------------------------------------------------------------------------
module cont_delay_net #(
    parameter int N_DRV = 2,
    parameter int W     = 1,
    parameter int DW    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_DRV*W*2-1:0]   drv_val,
    input  logic [N_DRV*DW-1:0]    dly_rise,
    input  logic [N_DRV*DW-1:0]    dly_fall,
    input  logic [N_DRV*DW-1:0]    dly_off,
    output logic [N_DRV*W*2-1:0]   drv_eff,
    output logic [N_DRV-1:0]       drv_busy,
    output logic [W*2-1:0]         net,
    output logic                   net_chg
);

    localparam int DV = 2 * W;
    localparam logic [DV-1:0] Z_VEC = {W{2'b10}};

    // Delay chosen from the driver's own target value, never from the net.
    function automatic logic [DW-1:0] sel_delay(
        input logic [DV-1:0] t,
        input logic [DW-1:0] r,
        input logic [DW-1:0] f,
        input logic [DW-1:0] o
    );
        logic          any_x;
        logic          any_z;
        logic          any_0;
        logic          any_1;
        logic [1:0]    c;
        logic [DW-1:0] m;
        any_x = 1'b0;
        any_z = 1'b0;
        any_0 = 1'b0;
        any_1 = 1'b0;
        for (int b = 0; b < W; b++) begin
            c = t[2*b +: 2];
            case (c)
                2'b00:   any_0 = 1'b1;
                2'b01:   any_1 = 1'b1;
                2'b10:   any_z = 1'b1;
                default: any_x = 1'b1;
            endcase
        end
        m = r;
        if (f < m) m = f;
        if (o < m) m = o;
        if (!any_x && !any_0 && !any_1)
            sel_delay = o;
        else if (any_x || any_z)
            sel_delay = m;
        else if (!any_1)
            sel_delay = f;
        else
            sel_delay = r;
    endfunction

    // Wire resolution: z contributions are ignored, agreement wins, anything
    // else (x or 0/1 conflict) yields x.
    function automatic logic [DV-1:0] resolve(input logic [N_DRV*DV-1:0] e);
        logic [DV-1:0] r;
        logic          h0;
        logic          h1;
        logic          hx;
        logic [1:0]    c;
        r = '0;
        for (int b = 0; b < W; b++) begin
            h0 = 1'b0;
            h1 = 1'b0;
            hx = 1'b0;
            for (int i = 0; i < N_DRV; i++) begin
                c = e[i*DV + 2*b +: 2];
                case (c)
                    2'b00:   h0 = 1'b1;
                    2'b01:   h1 = 1'b1;
                    2'b11:   hx = 1'b1;
                    default: ;
                endcase
            end
            if (hx || (h0 && h1))
                r[2*b +: 2] = 2'b11;
            else if (h0)
                r[2*b +: 2] = 2'b00;
            else if (h1)
                r[2*b +: 2] = 2'b01;
            else
                r[2*b +: 2] = 2'b10;
        end
        resolve = r;
    endfunction

    // Stage p0: per-driver inertial delay
    for (genvar i = 0; i < N_DRV; i++) begin : g_drv
        logic [DV-1:0] v_p0;
        logic [DV-1:0] eff_p0;
        logic [DV-1:0] tgt_p0;
        logic [DW-1:0] cnt_p0;
        logic [DW-1:0] d_p0;
        logic          busy_p0;

        assign v_p0 = drv_val[i*DV +: DV];
        assign d_p0 = sel_delay(v_p0,
                                dly_rise[i*DW +: DW],
                                dly_fall[i*DW +: DW],
                                dly_off[i*DW +: DW]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                eff_p0  <= Z_VEC;
                tgt_p0  <= Z_VEC;
                cnt_p0  <= '0;
                busy_p0 <= 1'b0;
            end else if (!busy_p0) begin
                if (v_p0 != eff_p0) begin
                    tgt_p0 <= v_p0;
                    cnt_p0 <= d_p0;
                    if (d_p0 == '0)
                        eff_p0 <= v_p0;
                    else
                        busy_p0 <= 1'b1;
                end
            end else if (v_p0 == tgt_p0) begin
                // Commit one edge after the counter reaches zero.
                if (cnt_p0 == '0) begin
                    eff_p0  <= tgt_p0;
                    busy_p0 <= 1'b0;
                end else begin
                    cnt_p0 <= cnt_p0 - 1'b1;
                end
            end else if (v_p0 == eff_p0) begin
                // Input returned before the delay expired: pulse rejected.
                busy_p0 <= 1'b0;
            end else begin
                // New target while pending: restart with a freshly chosen delay.
                tgt_p0 <= v_p0;
                cnt_p0 <= d_p0;
                if (d_p0 == '0) begin
                    eff_p0  <= v_p0;
                    busy_p0 <= 1'b0;
                end
            end
        end

        assign drv_eff[i*DV +: DV] = eff_p0;
        assign drv_busy[i]         = busy_p0;
    end

    // Stage p1: resolved net and change detection
    logic [DV-1:0] res_p0;
    logic [DV-1:0] net_prev_p2;

    assign res_p0 = resolve(drv_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net         <= Z_VEC;
            net_prev_p2 <= Z_VEC;
            net_chg     <= 1'b0;
        end else begin
            net         <= res_p0;
            net_prev_p2 <= net;
            net_chg     <= (net != net_prev_p2);
        end
    end

endmodule

// File: tb/tb_cont_delay_net.sv
module tb_cont_delay_net;

    localparam int N_DRV = 3;
    localparam int W     = 4;
    localparam int DW    = 4;
    localparam int DV    = 2 * W;

    logic                 clk;
    logic                 rst_n;
    logic [N_DRV*DV-1:0]  drv_val;
    logic [N_DRV*DW-1:0]  dly_rise;
    logic [N_DRV*DW-1:0]  dly_fall;
    logic [N_DRV*DW-1:0]  dly_off;
    logic [N_DRV*DV-1:0]  drv_eff;
    logic [N_DRV-1:0]     drv_busy;
    logic [DV-1:0]        net;
    logic                 net_chg;

    cont_delay_net #(.N_DRV(N_DRV), .W(W), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .drv_val  (drv_val),
        .dly_rise (dly_rise),
        .dly_fall (dly_fall),
        .dly_off  (dly_off),
        .drv_eff  (drv_eff),
        .drv_busy (drv_busy),
        .net      (net),
        .net_chg  (net_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // kind: 0 drv_eff[idx], 1 drv_busy[idx], 2 net, 3 net_chg
    typedef struct {
        int         ed;
        int         kind;
        int         idx;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] v4(input string s);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            case (s[k])
                "0":     r[(3-k)*2 +: 2] = 2'b00;
                "1":     r[(3-k)*2 +: 2] = 2'b01;
                "z":     r[(3-k)*2 +: 2] = 2'b10;
                default: r[(3-k)*2 +: 2] = 2'b11;
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] actual(input int kind, input int idx);
        case (kind)
            0:       return drv_eff[idx*DV +: DV];
            1:       return {7'b0, drv_busy[idx]};
            2:       return net;
            default: return {7'b0, net_chg};
        endcase
    endfunction

    task automatic push(input int ed, input int kind, input int idx,
                        input logic [7:0] val, input string name);
        exp_t e;
        e.ed = ed; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: after every edge, compare all expectations due at that edge.
    always @(negedge clk) begin
        logic [7:0] a;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].ed == edge_cnt) begin
                a = actual(sb[j].kind, sb[j].idx);
                checks++;
                if (a !== sb[j].val) begin
                    errors++;
                    $display("FAIL %s edge %0d got %b expected %b",
                             sb[j].name, edge_cnt, a, sb[j].val);
                end
                sb.delete(j);
            end
        end
    end

    // Position the stimulus so new inputs are sampled at edge n.
    task automatic to_edge(input int n);
        while (edge_cnt < n - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_val(input int i, input string s);
        drv_val[i*DV +: DV] = v4(s);
    endtask

    task automatic set_dly(input int i, input int r, input int f, input int o);
        dly_rise[i*DW +: DW] = DW'(r);
        dly_fall[i*DW +: DW] = DW'(f);
        dly_off[i*DW +: DW]  = DW'(o);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N_DRV; i++) begin
            set_val(i, "zzzz");
            set_dly(i, 0, 0, 0);
        end
    endtask

    task automatic do_reset(input int n);
        to_edge(n);
        rst_n = 1'b0;
        idle_inputs();
        to_edge(n + 2);
        rst_n = 1'b1;
    endtask

    int B, C, D, E, R, F, G;

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        for (int i = 0; i < N_DRV; i++) begin
            push(1, 0, i, v4("zzzz"), "rst_eff");
            push(1, 1, i, 8'd0, "rst_busy");
        end
        push(1, 2, 0, v4("zzzz"), "rst_net");
        push(1, 3, 0, 8'd0, "rst_chg");
        to_edge(3);
        rst_n = 1'b1;

        // Driver-relative delay selection
        B = 4;
        to_edge(B);
        set_dly(0, 0, 0, 0);
        set_val(0, "1111");
        set_dly(1, 1, 2, 1);
        push(B,     0, 0, v4("1111"), "t1_eff0");
        push(B + 1, 2, 0, v4("1111"), "t1_net_1");
        push(B + 2, 3, 0, 8'd1,       "t1_chg_first");
        push(B + 7, 0, 1, v4("zzzz"), "t1_eff1_early");
        push(B + 7, 1, 1, 8'd1,       "t1_busy1_pend");
        push(B + 8, 0, 1, v4("0000"), "t1_eff1_fall");
        push(B + 8, 1, 1, 8'd0,       "t1_busy1_done");
        push(B + 8, 2, 0, v4("1111"), "t1_net_lag");
        push(B + 9, 2, 0, v4("xxxx"), "t1_net_x");
        push(B + 9, 3, 0, 8'd0,       "t1_chg_pre");
        push(B + 10, 3, 0, 8'd1,      "t1_chg_pulse");
        push(B + 11, 3, 0, 8'd0,      "t1_chg_end");
        to_edge(B + 5);
        set_val(1, "0000");

        // x target uses min delay; mixed z/0/1 target too
        C = B + 12;
        to_edge(C);
        set_dly(2, 3, 5, 2);
        set_val(2, "xxxx");
        push(C + 2, 0, 2, v4("zzzz"), "t2_x_early");
        push(C + 3, 0, 2, v4("xxxx"), "t2_x_min");
        push(C + 9, 0, 2, v4("xxxx"), "t2_mix_early");
        push(C + 10, 0, 2, v4("z1z0"), "t2_mix_min");
        to_edge(C + 5);
        set_dly(2, 5, 6, 4);
        set_val(2, "z1z0");

        do_reset(C + 12);

        // Inertial rejection
        D = C + 15;
        to_edge(D);
        set_val(0, "1111");
        push(D + 2,  3, 0, 8'd1,       "t3_chg_rise");
        push(D + 10, 1, 0, 8'd1,       "t3_busy_sched");
        push(D + 11, 1, 0, 8'd1,       "t3_busy_hold");
        push(D + 12, 1, 0, 8'd0,       "t3_busy_cancel");
        push(D + 12, 0, 0, v4("1111"), "t3_eff_keep");
        push(D + 15, 0, 0, v4("1111"), "t3_eff_no_glitch");
        push(D + 13, 3, 0, 8'd0,       "t3_no_chg_a");
        push(D + 14, 3, 0, 8'd0,       "t3_no_chg_b");
        push(D + 16, 3, 0, 8'd0,       "t3_no_chg_c");
        push(D + 16, 2, 0, v4("1111"), "t3_net_keep");
        to_edge(D + 10);
        set_dly(0, 0, 4, 0);
        set_val(0, "0000");
        to_edge(D + 12);
        set_val(0, "1111");

        do_reset(D + 18);

        // Reschedule from pending rise to turn-off
        E = D + 21;
        R = E + 3;
        to_edge(E);
        set_dly(0, 6, 0, 2);
        set_val(0, "0000");
        push(E,     0, 0, v4("0000"), "t4_eff_init");
        push(R + 1, 0, 0, v4("0000"), "t4_eff_r1");
        push(R + 3, 0, 0, v4("0000"), "t4_eff_r3");
        push(R + 4, 0, 0, v4("0000"), "t4_eff_r4");
        push(R + 4, 1, 0, 8'd1,       "t4_busy_r4");
        push(R + 5, 0, 0, v4("zzzz"), "t4_eff_off");
        push(R + 5, 1, 0, 8'd0,       "t4_busy_done");
        push(R + 6, 2, 0, v4("zzzz"), "t4_net_z");
        to_edge(R);
        set_val(0, "1111");
        to_edge(R + 2);
        set_val(0, "zzzz");

        do_reset(R + 8);

        // Bitwise resolution with three drivers
        F = R + 11;
        to_edge(F);
        set_val(0, "01zz");
        set_val(1, "0z1z");
        set_val(2, "0xzz");
        push(F,     0, 0, v4("01zz"), "t5_eff0");
        push(F,     0, 1, v4("0z1z"), "t5_eff1");
        push(F,     0, 2, v4("0xzz"), "t5_eff2");
        push(F + 1, 2, 0, v4("0x1z"), "t5_net");
        push(F + 2, 3, 0, 8'd1,       "t5_chg");

        // Reset while a transition is pending
        G = F + 4;
        to_edge(G);
        set_dly(0, 5, 0, 0);
        set_val(0, "1111");
        push(G,     1, 0, 8'd1,       "t6_busy_pend");
        push(G,     0, 0, v4("01zz"), "t6_eff_hold");
        push(G + 1, 0, 0, v4("zzzz"), "t6_rst_eff0");
        push(G + 1, 0, 1, v4("zzzz"), "t6_rst_eff1");
        push(G + 1, 0, 2, v4("zzzz"), "t6_rst_eff2");
        push(G + 1, 1, 0, 8'd0,       "t6_rst_busy");
        push(G + 1, 2, 0, v4("zzzz"), "t6_rst_net");
        push(G + 1, 3, 0, 8'd0,       "t6_rst_chg");
        push(G + 5, 1, 0, 8'd0,       "t6_no_stale_busy");
        push(G + 6, 0, 0, v4("zzzz"), "t6_no_stale_eff");
        push(G + 8, 2, 0, v4("zzzz"), "t6_net_quiet");
        to_edge(G + 2);
        rst_n = 1'b0;
        idle_inputs();
        to_edge(G + 4);
        rst_n = 1'b1;

        to_edge(G + 12);
        @(negedge clk);
        #1;
        checks++;
        if (drv_busy !== '0) begin
            errors++;
            $display("FAIL end_busy got %b", drv_busy);
        end
        checks++;
        if (drv_eff !== {(N_DRV*W){2'b10}}) begin
            errors++;
            $display("FAIL end_eff got %b", drv_eff);
        end
        checks++;
        if (net !== {W{2'b10}}) begin
            errors++;
            $display("FAIL end_net got %b", net);
        end
        checks++;
        if (net_chg !== 1'b0) begin
            errors++;
            $display("FAIL end_chg got %b", net_chg);
        end
        // Any expectation the monitor never reached counts as a failure.
        foreach (sb[j]) begin
            checks++;
            errors++;
            $display("FAIL %s never checked at edge %0d", sb[j].name, sb[j].ed);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
